// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception controller: detects ecall/ebreak/mret and the
// timer interrupt, sequences the trap CSR writes and redirects the PC.
module clint_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] CAUSE_ECALL  = 32'd11,
  parameter logic [XLEN-1:0] CAUSE_EBREAK = 32'd3,
  parameter logic [XLEN-1:0] CAUSE_TIMER  = 32'h8000_0007
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            irq_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  output logic            csr_wr_en_o,
  output logic [XLEN-1:0] csr_wr_addr_o,
  output logic [XLEN-1:0] csr_wr_data_o,
  output logic            hold_flag_o,
  output logic            int_jump_o,
  output logic [XLEN-1:0] int_addr_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_W_MEPC    = 3'd1;
  localparam logic [2:0] S_W_MSTATUS = 3'd2;
  localparam logic [2:0] S_W_MCAUSE  = 3'd3;
  localparam logic [2:0] S_T_JUMP    = 3'd4;
  localparam logic [2:0] S_R_MSTATUS = 3'd5;
  localparam logic [2:0] S_R_JUMP    = 3'd6;

  localparam logic [XLEN-1:0] ADDR_MSTATUS = {{(XLEN-12){1'b0}}, 12'h300};
  localparam logic [XLEN-1:0] ADDR_MEPC    = {{(XLEN-12){1'b0}}, 12'h341};
  localparam logic [XLEN-1:0] ADDR_MCAUSE  = {{(XLEN-12){1'b0}}, 12'h342};

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            irq_take_s;

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1.
  function automatic logic [XLEN-1:0] mstatus_ret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  assign irq_take_s = irq_i & csr_mstatus_i[3];

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    hold_flag_o   = 1'b0;
    csr_wr_en_o   = 1'b0;
    csr_wr_addr_o = {XLEN{1'b0}};
    csr_wr_data_o = {XLEN{1'b0}};
    int_jump_o    = 1'b0;
    int_addr_o    = {XLEN{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (ecall_i) begin
          hold_flag_o = 1'b1;
          epc_d       = inst_addr_i;
          cause_d     = CAUSE_ECALL;
          state_d     = S_W_MEPC;
        end else if (ebreak_i) begin
          hold_flag_o = 1'b1;
          epc_d       = inst_addr_i;
          cause_d     = CAUSE_EBREAK;
          state_d     = S_W_MEPC;
        end else if (mret_i) begin
          hold_flag_o = 1'b1;
          state_d     = S_R_MSTATUS;
        end else if (irq_take_s) begin
          // An in-flight jump means the interrupted flow resumes at its target.
          hold_flag_o = 1'b1;
          epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d     = CAUSE_TIMER;
          state_d     = S_W_MEPC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_MEPC: begin
        hold_flag_o   = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = ADDR_MEPC;
        csr_wr_data_o = epc_q;
        state_d       = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        hold_flag_o   = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = ADDR_MSTATUS;
        csr_wr_data_o = mstatus_trap(csr_mstatus_i);
        state_d       = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_flag_o   = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = ADDR_MCAUSE;
        csr_wr_data_o = cause_q;
        state_d       = S_T_JUMP;
      end
      S_T_JUMP: begin
        hold_flag_o = 1'b1;
        int_jump_o  = 1'b1;
        int_addr_o  = csr_mtvec_i;
        state_d     = S_IDLE;
      end
      S_R_MSTATUS: begin
        hold_flag_o   = 1'b1;
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = ADDR_MSTATUS;
        csr_wr_data_o = mstatus_ret(csr_mstatus_i);
        state_d       = S_R_JUMP;
      end
      S_R_JUMP: begin
        hold_flag_o = 1'b1;
        int_jump_o  = 1'b1;
        int_addr_o  = csr_mepc_i;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched epc and cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      epc_q   <= {XLEN{1'b0}};
      cause_q <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Table-driven bench for clint_ctrl with an expected-value queue.
module tb_clint_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ecall_i, ebreak_i, mret_i, irq_i, jump_flag_i;
  logic [31:0] inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        csr_wr_en_o, hold_flag_o, int_jump_o;
  logic [31:0] csr_wr_addr_o, csr_wr_data_o, int_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        e, b, m, q, jf;
    logic [31:0] pc, ja, ms;
    logic        h, we, j;
    logic [31:0] wa, wd, ia;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  clint_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .irq_i(irq_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .csr_wr_en_o(csr_wr_en_o), .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
    .hold_flag_o(hold_flag_o), .int_jump_o(int_jump_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, b, m, q, input logic [31:0] pc,
                              input logic jf, input logic [31:0] ja, ms,
                              input logic h, we, input logic [31:0] wa, wd,
                              input logic j, input logic [31:0] ia);
    vec_t v;
    v.e = e; v.b = b; v.m = m; v.q = q; v.pc = pc; v.jf = jf; v.ja = ja; v.ms = ms;
    v.h = h; v.we = we; v.wa = wa; v.wd = wd; v.j = j; v.ia = ia;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @vec %0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after posedge, compare on the following negedge.
  task automatic apply(input vec_t v, input int idx);
    vec_t x;
    ecall_i = v.e; ebreak_i = v.b; mret_i = v.m; irq_i = v.q;
    inst_addr_i = v.pc; jump_flag_i = v.jf; jump_addr_i = v.ja; csr_mstatus_i = v.ms;
    exp_q.push_back(v);
    @(negedge clk);
    x = exp_q.pop_front();
    chk("hold",    idx, {31'd0, hold_flag_o}, {31'd0, x.h});
    chk("wr_en",   idx, {31'd0, csr_wr_en_o}, {31'd0, x.we});
    chk("wr_addr", idx, csr_wr_addr_o, x.wa);
    chk("wr_data", idx, csr_wr_data_o, x.wd);
    chk("jump",    idx, {31'd0, int_jump_o}, {31'd0, x.j});
    chk("jaddr",   idx, int_addr_o, x.ia);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle8;
    rst_n = 1'b0;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0; jump_flag_i = 1'b0;
    inst_addr_i = 32'h0; jump_addr_i = 32'h0; csr_mstatus_i = 32'h0;
    csr_mtvec_i = 32'h200; csr_mepc_i = 32'h104;
    idle8 = mk(0,0,0,0, 32'h0, 0, 32'h0, 32'h8, 0,0, 32'h0, 32'h0, 0, 32'h0);

    // ecall at 0x100; ecall held high while busy is ignored
    tbl.push_back(mk(1,0,0,0, 32'h100, 0, 32'h0, 32'h8, 1,0, 32'h0,   32'h0,  0, 32'h0));
    tbl.push_back(mk(1,0,0,0, 32'h1F0, 0, 32'h0, 32'h8, 1,1, 32'h341, 32'h100, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0, 32'h8, 1,1, 32'h300, 32'h80, 0, 32'h0));
    tbl.push_back(mk(0,0,1,0, 32'h0,   0, 32'h0, 32'h8, 1,1, 32'h342, 32'd11, 0, 32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h8, 1,0, 32'h0,   32'h0,  1, 32'h200));
    tbl.push_back(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h80, 0,0, 32'h0,  32'h0,  0, 32'h0));
    // mret, mepc=0x104, mstatus=0x80
    tbl.push_back(mk(0,0,1,0, 32'h0, 0, 32'h0, 32'h80, 1,0, 32'h0,   32'h0,  0, 32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0, 0, 32'h0, 32'h80, 1,1, 32'h300, 32'h88, 0, 32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0, 0, 32'h0, 32'h80, 1,0, 32'h0,   32'h0,  1, 32'h104));
    // interrupt with jump in flight
    tbl.push_back(mk(0,0,0,1, 32'h2F0, 1, 32'h300, 32'h8, 1,0, 32'h0,   32'h0, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h8, 1,1, 32'h341, 32'h300, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h8, 1,1, 32'h300, 32'h80, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h80, 1,1, 32'h342, 32'h80000007, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h80, 1,0, 32'h0,   32'h0, 1, 32'h200));
    // irq still high, MIE now 0: not retaken
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h80, 0,0, 32'h0,   32'h0, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h2F4, 1, 32'h310, 32'h1800, 0,0, 32'h0, 32'h0, 0, 32'h0));
    // ecall and irq together: ecall wins; other mstatus bits preserved
    tbl.push_back(mk(1,0,0,1, 32'h400, 0, 32'h0, 32'h1808, 1,0, 32'h0,   32'h0,    0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0, 32'h1808, 1,1, 32'h341, 32'h400,  0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0, 32'h1808, 1,1, 32'h300, 32'h1880, 0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0, 32'h1808, 1,1, 32'h342, 32'd11,   0, 32'h0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   0, 32'h0, 32'h1808, 1,0, 32'h0,   32'h0,    1, 32'h200));
    // back-to-back mret right after the jump; MPIE=0 restores MIE=0
    tbl.push_back(mk(0,0,1,0, 32'h0, 0, 32'h0, 32'h1800, 1,0, 32'h0,   32'h0,    0, 32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0, 0, 32'h0, 32'h1800, 1,1, 32'h300, 32'h1880, 0, 32'h0));
    tbl.push_back(mk(0,0,0,0, 32'h0, 0, 32'h0, 32'h1800, 1,0, 32'h0,   32'h0,    1, 32'h104));
    tbl.push_back(mk(0,0,0,0, 32'h0, 0, 32'h0, 32'h1800, 0,0, 32'h0,   32'h0,    0, 32'h0));

    repeat (2) @(posedge clk);
    #1;
    apply(idle8, -1);
    rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i], i);

    // reset asserted while writing mstatus aborts the trap
    apply(mk(1,0,0,0, 32'h600, 0, 32'h0, 32'h8, 1,0, 32'h0,   32'h0,   0, 32'h0), 100);
    apply(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h8, 1,1, 32'h341, 32'h600, 0, 32'h0), 101);
    rst_n = 1'b0;
    apply(idle8, 102);
    rst_n = 1'b1;
    apply(idle8, 103);
    apply(mk(0,1,0,0, 32'h700, 0, 32'h0, 32'h8, 1,0, 32'h0,   32'h0,   0, 32'h0), 104);
    apply(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h8, 1,1, 32'h341, 32'h700, 0, 32'h0), 105);
    apply(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h8, 1,1, 32'h300, 32'h80,  0, 32'h0), 106);
    apply(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h8, 1,1, 32'h342, 32'd3,   0, 32'h0), 107);
    apply(mk(0,0,0,0, 32'h0,   0, 32'h0, 32'h8, 1,0, 32'h0,   32'h0,   1, 32'h200), 108);
    apply(idle8, 109);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
